rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter AW, 5, register address width (32 registers).
REQ-002 Parameter DW, 32, register data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 Freeze  input  1  pipeline stall; no grants while high.
REQ-006 AReqValid / AReqAddress / AReqData  input  1 / AW / DW  requester A (ALU writeback) write request.
REQ-007 AReqReady  output  1  requester A accepted this cycle.
REQ-008 BReqValid / BReqAddress / BReqData  input  1 / AW / DW  requester B (load unit) write request.
REQ-009 BReqReady  output  1  requester B accepted this cycle.
REQ-010 WriteAddress / WriteData / ReadWriteEn  output  AW / DW / 1  registered drive of the register_file write port.
REQ-011 With RF_BYPASS_EN only: ReadAddress1/2 input AW, RfReadData1/2 input DW (from register_file), ReadData1/2 output DW (forwarded).

Function
REQ-012 Handshake: a request is accepted in the cycle where Valid and Ready are both high; at most one accept per cycle.
REQ-013 Ready is combinational from Valid, Freeze and arbiter pointer; Ready never high while Valid low or Freeze high.
REQ-014 Only one requester valid, Freeze low: that requester gets Ready.
REQ-015 Both valid, Freeze low: grant the requester not granted last (round-robin pointer LastGrant); LastGrant updates only on an accept.
REQ-016 Requester holds Address/Data stable while Valid high and not accepted; the block does not check this.
REQ-017 Latency: accepted write appears on WriteAddress/WriteData with ReadWriteEn=1 in the next cycle, exactly one cycle, committed by register_file on the following edge.
REQ-018 No accept in a cycle: ReadWriteEn=0 next cycle; WriteAddress/WriteData hold previous values.
REQ-019 Address 0 write: accepted (Ready high) but ReadWriteEn stays 0 next cycle; register 0 never written through this block.
REQ-020 Both requesters targeting the same address in consecutive grants: both issued in grant order; the later grant's data is final.
REQ-021 Freeze asserted while a write is registered: that write still issues (ReadWriteEn is not suppressed); only new grants stall.

Reset
REQ-022 rst high at an edge: ReadWriteEn=0, WriteAddress=0, WriteData=0, LastGrant=B (A wins the first contention).
REQ-023 Reset mid-operation discards any registered, not-yet-issued write; AReqReady/BReqReady are 0 while rst high.

Configuration
REQ-024 Macro RF_BYPASS_EN defined: ReadDataN = WriteData when ReadWriteEn=1 and WriteAddress==ReadAddressN and ReadAddressN!=0, else RfReadDataN; both ports independent, combinational.
REQ-025 Macro RF_BYPASS_EN undefined: read ports absent; no forwarding logic; write-arbitration behaviour identical.

Structure
REQ-026 Package rf_pkg holds AW, DW and requester index constants REQ_A=0, REQ_B=1.
REQ-027 Sub-module rr_arbiter2 implements the two-way round-robin grant and LastGrant flop; top holds output register and bypass mux.

Verification
REQ-028 A only: A writes addr 8 data 294 at cycle 1 -> AReqReady=1 cycle 1; cycle 2 WriteAddress=8, WriteData=294, ReadWriteEn=1.
REQ-029 Contention after reset: A(13,194) and B(3,48) valid together -> A granted first, B next cycle; outputs 13/194 then 3/48 on consecutive cycles.
REQ-030 Sustained contention 4 cycles: grants alternate A,B,A,B; no requester waits more than 1 cycle.
REQ-031 Freeze high 3 cycles with A valid (10,123) -> AReqReady=0 throughout, ReadWriteEn=0; Freeze drops -> accept, write issued next cycle.
REQ-032 B writes addr 0 data 55 -> BReqReady=1, next cycle ReadWriteEn=0.
REQ-033 RF_BYPASS_EN: write (8,294) in flight, ReadAddress1=8, RfReadData1=7 -> ReadData1=294; ReadAddress2=13 -> ReadData2=RfReadData2; rst asserted with write pending -> ReadWriteEn=0 next cycle, no forwarding.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and requester indices for the register-file write arbiter.
package rf_pkg;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with LastGrant pointer.
// Grants are combinational; the pointer only moves on an actual grant.
module rr_arbiter2
  import rf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic freeze,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);

  req_e last_grant_q, last_grant_d;

  // Grant selection: single requester wins outright, contention goes to the one not granted last
  always_comb begin
    a_grant      = 1'b0;
    b_grant      = 1'b0;
    last_grant_d = last_grant_q;
    if (!rst && !freeze) begin
      if (a_valid && b_valid) begin
        if (last_grant_q == REQ_B) a_grant = 1'b1;
        else                       b_grant = 1'b1;
      end else begin
        a_grant = a_valid;
        b_grant = b_valid;
      end
    end
    if (a_grant)      last_grant_d = REQ_A;
    else if (b_grant) last_grant_d = REQ_B;
  end

  // Pointer register; reset to B so A wins the first contention
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= REQ_B;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates ALU (A) and load-unit (B) writebacks onto a
// single register_file write port with a one-cycle registered drive.
// Optional macro RF_BYPASS_EN adds two read ports that forward the in-flight write.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned AW = rf_pkg::AW,
  parameter int unsigned DW = rf_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Freeze,
  input  logic          AReqValid,
  input  logic [AW-1:0] AReqAddress,
  input  logic [DW-1:0] AReqData,
  output logic          AReqReady,
  input  logic          BReqValid,
  input  logic [AW-1:0] BReqAddress,
  input  logic [DW-1:0] BReqData,
  output logic          BReqReady,
`ifdef RF_BYPASS_EN
  input  logic [AW-1:0] ReadAddress1,
  input  logic [AW-1:0] ReadAddress2,
  input  logic [DW-1:0] RfReadData1,
  input  logic [DW-1:0] RfReadData2,
  output logic [DW-1:0] ReadData1,
  output logic [DW-1:0] ReadData2,
`endif
  output logic [AW-1:0] WriteAddress,
  output logic [DW-1:0] WriteData,
  output logic          ReadWriteEn
);

  logic          a_grant, b_grant;
  logic [AW-1:0] write_address_q, write_address_d;
  logic [DW-1:0] write_data_q, write_data_d;
  logic          write_en_q, write_en_d;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .freeze  (Freeze),
    .a_valid (AReqValid),
    .b_valid (BReqValid),
    .a_grant (a_grant),
    .b_grant (b_grant)
  );

  assign AReqReady = a_grant;
  assign BReqReady = b_grant;

  // Next write-port drive: an accepted write to a nonzero register issues next cycle;
  // address/data only change when a write actually issues, otherwise they hold
  always_comb begin
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    write_en_d      = 1'b0;
    if (a_grant && (AReqAddress != '0)) begin
      write_address_d = AReqAddress;
      write_data_d    = AReqData;
      write_en_d      = 1'b1;
    end else if (b_grant && (BReqAddress != '0)) begin
      write_address_d = BReqAddress;
      write_data_d    = BReqData;
      write_en_d      = 1'b1;
    end
  end

  // Write-port register; reset drops any pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      write_address_q <= '0;
      write_data_q    <= '0;
      write_en_q      <= 1'b0;
    end else begin
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      write_en_q      <= write_en_d;
    end
  end

  assign WriteAddress = write_address_q;
  assign WriteData    = write_data_q;
  assign ReadWriteEn  = write_en_q;

`ifdef RF_BYPASS_EN
  // Forward the in-flight write to each read port independently; register 0 never forwards
  always_comb begin
    ReadData1 = RfReadData1;
    ReadData2 = RfReadData2;
    if (write_en_q && (write_address_q == ReadAddress1) && (ReadAddress1 != '0))
      ReadData1 = write_data_q;
    if (write_en_q && (write_address_q == ReadAddress2) && (ReadAddress2 != '0))
      ReadData2 = write_data_q;
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: scoreboard bench for rf_write_arbiter (bypass ports when RF_BYPASS_EN).
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int unsigned TAW = rf_pkg::AW;
  localparam int unsigned TDW = rf_pkg::DW;

  typedef struct packed {
    logic [TAW-1:0] addr;
    logic [TDW-1:0] data;
  } wr_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           Freeze;
  logic           AReqValid, BReqValid;
  logic [TAW-1:0] AReqAddress, BReqAddress;
  logic [TDW-1:0] AReqData, BReqData;
  logic           AReqReady, BReqReady;
  logic [TAW-1:0] WriteAddress;
  logic [TDW-1:0] WriteData;
  logic           ReadWriteEn;
`ifdef RF_BYPASS_EN
  logic [TAW-1:0] ReadAddress1, ReadAddress2;
  logic [TDW-1:0] RfReadData1, RfReadData2, ReadData1, ReadData2;
`endif

  always #5 clk = ~clk;

  rf_write_arbiter #(.AW(TAW), .DW(TDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .Freeze       (Freeze),
    .AReqValid    (AReqValid),
    .AReqAddress  (AReqAddress),
    .AReqData     (AReqData),
    .AReqReady    (AReqReady),
    .BReqValid    (BReqValid),
    .BReqAddress  (BReqAddress),
    .BReqData     (BReqData),
    .BReqReady    (BReqReady),
`ifdef RF_BYPASS_EN
    .ReadAddress1 (ReadAddress1),
    .ReadAddress2 (ReadAddress2),
    .RfReadData1  (RfReadData1),
    .RfReadData2  (RfReadData2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
`endif
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData),
    .ReadWriteEn  (ReadWriteEn)
  );

  int unsigned    n_checks = 0;
  int unsigned    n_errors = 0;
  wr_t            sb[$];
  req_e           last_m   = REQ_B;
  logic           m_we     = 1'b0;
  logic [TAW-1:0] m_addr   = '0;
  logic [TDW-1:0] m_data   = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check readies at negedge, check write port after the edge
  task automatic drive_cycle(input logic av, input logic [TAW-1:0] aa, input logic [TDW-1:0] ad,
                             input logic bv, input logic [TAW-1:0] ba, input logic [TDW-1:0] bd,
                             input logic frz, output logic obs_a, output logic obs_b);
    logic exp_a, exp_b;
    wr_t  e;
    AReqValid = av; AReqAddress = aa; AReqData = ad;
    BReqValid = bv; BReqAddress = ba; BReqData = bd;
    Freeze    = frz;
    @(negedge clk);
    check_eq("we_midcycle", ReadWriteEn, m_we);
    exp_a = !rst && !frz && av && (!bv || last_m == REQ_B);
    exp_b = !rst && !frz && bv && (!av || last_m == REQ_A);
    check_eq("a_ready", AReqReady, exp_a);
    check_eq("b_ready", BReqReady, exp_b);
    obs_a = AReqReady;
    obs_b = BReqReady;
    if (exp_a) begin
      last_m = REQ_A;
      if (aa != '0) begin e.addr = aa; e.data = ad; sb.push_back(e); end
    end
    if (exp_b) begin
      last_m = REQ_B;
      if (ba != '0) begin e.addr = ba; e.data = bd; sb.push_back(e); end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      m_we = 1'b0; m_addr = '0; m_data = '0; last_m = REQ_B;
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
      m_we = 1'b1; m_addr = e.addr; m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    check_eq("write_en", ReadWriteEn, m_we);
    check_eq("write_addr", WriteAddress, m_addr);
    check_eq("write_data", WriteData, m_data);
`ifdef RF_BYPASS_EN
    ReadAddress1 = ($urandom_range(0, 1) == 1) ? m_addr : TAW'($urandom_range(0, 31));
    ReadAddress2 = ($urandom_range(0, 3) == 0) ? m_addr : TAW'($urandom_range(0, 31));
    RfReadData1  = $urandom;
    RfReadData2  = $urandom;
    #1;
    check_eq("bypass1", ReadData1,
             (m_we && m_addr == ReadAddress1 && ReadAddress1 != '0) ? m_data : RfReadData1);
    check_eq("bypass2", ReadData2,
             (m_we && m_addr == ReadAddress2 && ReadAddress2 != '0) ? m_data : RfReadData2);
`endif
  endtask

  initial begin
    logic           oa, ob;
    int unsigned    wa, wb;
    logic           ra_v, rb_v;
    logic [TAW-1:0] ra_a, rb_a;
    logic [TDW-1:0] ra_d, rb_d;

    rst = 1'b1; Freeze = 1'b0;
    AReqValid = 1'b0; AReqAddress = '0; AReqData = '0;
    BReqValid = 1'b0; BReqAddress = '0; BReqData = '0;
`ifdef RF_BYPASS_EN
    ReadAddress1 = '0; ReadAddress2 = '0; RfReadData1 = '0; RfReadData2 = '0;
`endif
    @(posedge clk);
    #1;

    // reset: readies stay low even with requests pending, outputs cleared
    drive_cycle(1'b1, 5'd8, 32'd294, 1'b1, 5'd3, 32'd48, 1'b0, oa, ob);
    drive_cycle(1'b1, 5'd8, 32'd294, 1'b0, '0, '0, 1'b0, oa, ob);
    rst = 1'b0;

    // A only: accept then one-cycle write, then idle holds address/data
    drive_cycle(1'b1, 5'd8, 32'd294, 1'b0, '0, '0, 1'b0, oa, ob);
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, oa, ob);

    // contention straight after reset: A first, then B
    rst = 1'b1;
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, oa, ob);
    rst = 1'b0;
    drive_cycle(1'b1, 5'd13, 32'd194, 1'b1, 5'd3, 32'd48, 1'b0, oa, ob);
    check_eq("first_contention_a", {oa, ob}, 2'b10);
    drive_cycle(1'b0, '0, '0, 1'b1, 5'd3, 32'd48, 1'b0, oa, ob);

    // sustained contention: alternation A,B,A,B and bounded wait
    ra_a = 5'd20; ra_d = 32'h100; rb_a = 5'd21; rb_d = 32'h200;
    wa = 0; wb = 0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, ra_a, ra_d, 1'b1, rb_a, rb_d, 1'b0, oa, ob);
      check_eq("alternate", {oa, ob}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (oa) begin wa = 0; ra_a = ra_a + 5'd2; ra_d = ra_d + 32'd1; end else wa++;
      if (ob) begin wb = 0; rb_a = rb_a + 5'd2; rb_d = rb_d + 32'd1; end else wb++;
      check_eq("a_wait_le1", (wa <= 1), 1'b1);
      check_eq("b_wait_le1", (wb <= 1), 1'b1);
    end

    // freeze stalls new grants, then release accepts
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, 5'd10, 32'd123, 1'b0, '0, '0, 1'b1, oa, ob);
    drive_cycle(1'b1, 5'd10, 32'd123, 1'b0, '0, '0, 1'b0, oa, ob);
    // freeze during a registered write: it still issues (mid-cycle check)
    drive_cycle(1'b1, 5'd11, 32'd7, 1'b0, '0, '0, 1'b1, oa, ob);
    drive_cycle(1'b1, 5'd11, 32'd7, 1'b0, '0, '0, 1'b0, oa, ob);

    // B to register 0: accepted but never written
    drive_cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'd55, 1'b0, oa, ob);
    check_eq("b_addr0_ready", ob, 1'b1);
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, oa, ob);

    // same address from both, back-to-back: grant order preserved
    drive_cycle(1'b1, 5'd5, 32'd11, 1'b1, 5'd5, 32'd22, 1'b0, oa, ob);
    drive_cycle(1'b0, '0, '0, 1'b1, 5'd5, 32'd22, 1'b0, oa, ob);
    check_eq("same_addr_final", {WriteAddress, WriteData}, {5'd5, 32'd22});

    // reset while a write is on the port discards it
    drive_cycle(1'b1, 5'd8, 32'd294, 1'b0, '0, '0, 1'b0, oa, ob);
    rst = 1'b1;
    drive_cycle(1'b1, 5'd7, 32'd1, 1'b1, 5'd6, 32'd2, 1'b0, oa, ob);
    rst = 1'b0;

    // random traffic with requesters holding until accepted
    ra_v = 1'b0; rb_v = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!ra_v) begin ra_v = 1'($urandom_range(0, 1)); ra_a = TAW'($urandom_range(0, 31)); ra_d = $urandom; end
      if (!rb_v) begin rb_v = 1'($urandom_range(0, 1)); rb_a = TAW'($urandom_range(0, 31)); rb_d = $urandom; end
      drive_cycle(ra_v, ra_a, ra_d, rb_v, rb_a, rb_d, ($urandom_range(0, 3) == 0), oa, ob);
      if (oa) ra_v = 1'b0;
      if (ob) rb_v = 1'b0;
    end
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, oa, ob);
    check_eq("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
